ama_riscv_id_ex_reg: RTL
========================

# ama_riscv_id_ex_reg

ID/EX pipeline register that sits directly upstream of the integer ALU. It captures one decoded instruction per cycle and holds it under downstream back-pressure. It resolves RAW hazards by forwarding from the MEM and WB stages and suppresses issue while a load result is still in flight. It then drives the ALU opcode and both ALU operands, plus store data and writeback control, to the EX stage.

## Interface
- `RF_AW`, default 5: register-file address width.
- `XLEN`, default 32: datapath width.

- `clk` in 1: core clock.
- `rst_n` in 1: asynchronous active-low reset.
- `id_valid` in 1: decode presents an instruction.
- `id_ready` out 1: register can accept this cycle.
- `id_pc` in XLEN: instruction PC.
- `id_imm` in XLEN: sign-extended immediate.
- `id_op_sel` in 4: ALU operation code (shared ALU encoding).
- `id_a_sel` in 1: ALU A is 0 = rs1, 1 = PC.
- `id_b_sel` in 1: ALU B is 0 = rs2, 1 = imm.
- `id_rs1`, `id_rs2` in RF_AW: source addresses.
- `id_rs1_use`, `id_rs2_use` in 1: instruction actually reads the source.
- `id_rs1_data`, `id_rs2_data` in XLEN: register-file read data.
- `id_rd` in RF_AW: destination.
- `id_rd_we` in 1: destination write enable.
- `flush` in 1: kill the held instruction and the incoming one (branch/jump redirect).
- `fwd_mem_we` in 1: MEM stage writes a register.
- `fwd_mem_rd` in RF_AW: MEM destination.
- `fwd_mem_data` in XLEN: MEM result.
- `fwd_mem_pend` in 1: MEM result not yet available (load in flight).
- `fwd_wb_we` in 1: WB stage writes a register.
- `fwd_wb_rd` in RF_AW: WB destination.
- `fwd_wb_data` in XLEN: WB result.
- `ex_valid` out 1: EX may consume the instruction.
- `ex_ready` in 1: EX accepts this cycle.
- `ex_op_sel` out 4: ALU opcode.
- `ex_in_a`, `ex_in_b` out XLEN: ALU operands.
- `ex_store_data` out XLEN: forwarded rs2 value.
- `ex_pc` out XLEN: PC of the held instruction.
- `ex_rd` out RF_AW: destination.
- `ex_rd_we` out 1: gated by `ex_valid`.

## Operation
- State machine with two states:
  - EMPTY → FULL on `id_valid && id_ready && !flush`.
  - FULL → EMPTY on an EX fire (`ex_valid && ex_ready`) with no new capture, or on `flush`.
  - FULL → FULL on a simultaneous fire and capture.
- `id_ready = !full || (ex_valid && ex_ready)`.
  - This is a combinational path from `ex_ready`; the block has no bubble on back-to-back issue.
- Capture stores all `id_*` fields.
  - The stored rs values take the WB bypass: if `fwd_wb_we`, the source is nonzero, and `fwd_wb_rd` matches, store `fwd_wb_data`.
- Combinational forwarding is applied to each stored source when the source is used, its address is nonzero, and the stage's write enable is set:
  - MEM match (`fwd_mem_we`, `fwd_mem_rd == rs`) has first priority, taking `fwd_mem_data`.
  - WB match has second priority.
  - Otherwise the stored value is used.
- Refresh: every cycle the block is FULL and the entry does not fire, the stored rs value is overwritten with the forwarded value. A producer that retires during a hold is therefore not lost.
- Stall: a source stalls when it is used, its address is nonzero, and it matches MEM with `fwd_mem_pend` set.
  - `ex_valid = full && !stall_rs1 && !stall_rs2`.
  - A pending MEM match blocks issue even if WB also matches.
- Operand muxing:
  - `ex_in_a = a_sel ? pc : fwd_rs1`.
  - `ex_in_b = b_sel ? imm : fwd_rs2`.
  - `ex_store_data = fwd_rs2`.
- x0 is never forwarded and never stalls. Its stored value is whatever the register file returned, which is 0.
- `flush` has priority over capture and over fire. The next state is EMPTY whatever `id_valid` and `ex_ready` are.

## Timing
- Reset values: state EMPTY; every stored field 0; therefore `ex_valid`=0, `ex_rd_we`=0, `ex_op_sel`=0, and all data outputs 0.
  - `id_ready`=1 while in reset.
- Latency: capture at edge N gives `ex_valid` at N+1 when no stall is active. Throughput is 1 instruction per cycle.
- Handshake rules:
  - The `ex_*` control fields stay stable while `ex_valid && !ex_ready`.
  - The operand outputs may change only through forwarding, which refines them to the architecturally correct value.
- Asserting `rst_n` low mid-operation clears the entry immediately. The held instruction is dropped.
- Stall cycles are unbounded: the entry holds until `fwd_mem_pend` drops or the producer reaches WB.

## Structure
- Shared package `ama_riscv_pkg`: `XLEN`, `RF_AW`, the ALU opcode constants, and the A/B select enums (`ALU_A_RS1`/`ALU_A_PC`, `ALU_B_RS2`/`ALU_B_IMM`).
- One sub-module, `ama_riscv_fwd_mux`, instantiated twice (rs1, rs2). It takes the stored value plus the MEM and WB ports and returns the forwarded value and the stall flag.

## Test plan
- Back-to-back issue: `addi` imm=5 then `add`, both with `ex_ready`=1 → each has `ex_valid` the cycle after capture, op_sel preserved, and `id_ready` held at 1.
- MEM forward: held rs1=x3, stored value 0x10, MEM writes x3=0x55 → `ex_in_a`=0x55. The same with rs1=x0 → `ex_in_a`=0.
- Load-use: held rs2=x7 with MEM x7 pend=1 for 2 cycles, then WB x7=0xABCD → `ex_valid`=0 for 2 cycles, then 1 with `ex_in_b`=0xABCD.
- Hold refresh: `ex_ready`=0 for 3 cycles while WB writes x4=0x99 in cycle 1 only; held rs1=x4 → `ex_in_a`=0x99 in cycles 1-3 and at the fire.
- Flush: FULL, `id_valid`=1 and `flush`=1 in the same cycle → next cycle `ex_valid`=0 and EMPTY; the incoming instruction never appears.
- Async reset while FULL and stalled → outputs 0 before the next clock edge; after release, the first captured instruction issues normally.

Source files
------------

// File: rtl/ama_riscv_pkg.sv
// Shared core definitions: datapath widths, ALU opcodes, operand selects and ID/EX state.
package ama_riscv_pkg;

  localparam int XLEN  = 32;
  localparam int RF_AW = 5;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  typedef enum logic { ALU_A_RS1 = 1'b0, ALU_A_PC  = 1'b1 } alu_a_sel_t;
  typedef enum logic { ALU_B_RS2 = 1'b0, ALU_B_IMM = 1'b1 } alu_b_sel_t;

  typedef enum logic { ID_EX_EMPTY = 1'b0, ID_EX_FULL = 1'b1 } id_ex_state_t;

endpackage

// File: rtl/ama_riscv_id_ex_reg_if.sv
// Decode-side, forwarding-side and EX-side signals of the ID/EX register; master drives decode/fwd.
interface ama_riscv_id_ex_reg_if #(
  parameter int RF_AW = ama_riscv_pkg::RF_AW,
  parameter int XLEN  = ama_riscv_pkg::XLEN
) ();
  import ama_riscv_pkg::*;

  logic             id_valid;
  logic             id_ready;
  logic [XLEN-1:0]  id_pc;
  logic [XLEN-1:0]  id_imm;
  logic [3:0]       id_op_sel;
  alu_a_sel_t       id_a_sel;
  alu_b_sel_t       id_b_sel;
  logic [RF_AW-1:0] id_rs1;
  logic [RF_AW-1:0] id_rs2;
  logic             id_rs1_use;
  logic             id_rs2_use;
  logic [XLEN-1:0]  id_rs1_data;
  logic [XLEN-1:0]  id_rs2_data;
  logic [RF_AW-1:0] id_rd;
  logic             id_rd_we;
  logic             flush;

  logic             fwd_mem_we;
  logic [RF_AW-1:0] fwd_mem_rd;
  logic [XLEN-1:0]  fwd_mem_data;
  logic             fwd_mem_pend;
  logic             fwd_wb_we;
  logic [RF_AW-1:0] fwd_wb_rd;
  logic [XLEN-1:0]  fwd_wb_data;

  logic             ex_valid;
  logic             ex_ready;
  logic [3:0]       ex_op_sel;
  logic [XLEN-1:0]  ex_in_a;
  logic [XLEN-1:0]  ex_in_b;
  logic [XLEN-1:0]  ex_store_data;
  logic [XLEN-1:0]  ex_pc;
  logic [RF_AW-1:0] ex_rd;
  logic             ex_rd_we;

  modport master (
    output id_valid, id_pc, id_imm, id_op_sel, id_a_sel, id_b_sel, id_rs1, id_rs2,
           id_rs1_use, id_rs2_use, id_rs1_data, id_rs2_data, id_rd, id_rd_we, flush,
           fwd_mem_we, fwd_mem_rd, fwd_mem_data, fwd_mem_pend, fwd_wb_we, fwd_wb_rd,
           fwd_wb_data, ex_ready,
    input  id_ready, ex_valid, ex_op_sel, ex_in_a, ex_in_b, ex_store_data, ex_pc, ex_rd,
           ex_rd_we
  );

  modport slave (
    input  id_valid, id_pc, id_imm, id_op_sel, id_a_sel, id_b_sel, id_rs1, id_rs2,
           id_rs1_use, id_rs2_use, id_rs1_data, id_rs2_data, id_rd, id_rd_we, flush,
           fwd_mem_we, fwd_mem_rd, fwd_mem_data, fwd_mem_pend, fwd_wb_we, fwd_wb_rd,
           fwd_wb_data, ex_ready,
    output id_ready, ex_valid, ex_op_sel, ex_in_a, ex_in_b, ex_store_data, ex_pc, ex_rd,
           ex_rd_we
  );

endinterface

// File: rtl/ama_riscv_fwd_mux.sv
// Per-source bypass select (MEM over WB over stored) plus load-use stall flag.
// Purely combinational, zero latency; produces the stall that back-pressures issue.
module ama_riscv_fwd_mux #(
  parameter int RF_AW = 5,
  parameter int XLEN  = 32
) (
  input  logic             rs_use,
  input  logic [RF_AW-1:0] rs,
  input  logic [XLEN-1:0]  rs_dat,
  input  logic             mem_we,
  input  logic [RF_AW-1:0] mem_rd,
  input  logic [XLEN-1:0]  mem_dat,
  input  logic             mem_pend,
  input  logic             wb_we,
  input  logic [RF_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]  wb_dat,
  output logic [XLEN-1:0]  fwd_dat,
  output logic             stall
);

  logic src_live;
  logic mem_hit;
  logic wb_hit;

  // x0 is hardwired zero, so it never matches a producer
  assign src_live = rs_use && (rs != '0);
  assign mem_hit  = src_live && mem_we && (mem_rd == rs);
  assign wb_hit   = src_live && wb_we  && (wb_rd  == rs);
  assign stall    = mem_hit && mem_pend;

  always_comb begin
    fwd_dat = rs_dat;
    if (mem_hit) begin
      fwd_dat = mem_dat;
    end else if (wb_hit) begin
      fwd_dat = wb_dat;
    end
  end

endmodule

// File: rtl/ama_riscv_id_ex_reg.sv
// ID/EX register with MEM/WB forwarding and load-use stall in front of the ALU.
// Capture at edge N issues at N+1; holds under ex_ready low, id_ready passes through on fire.
module ama_riscv_id_ex_reg #(
  parameter int RF_AW = ama_riscv_pkg::RF_AW,
  parameter int XLEN  = ama_riscv_pkg::XLEN
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ama_riscv_id_ex_reg_if.slave bus
);
  import ama_riscv_pkg::*;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  imm;
    logic [3:0]       op_sel;
    alu_a_sel_t       a_sel;
    alu_b_sel_t       b_sel;
    logic [RF_AW-1:0] rs1;
    logic [RF_AW-1:0] rs2;
    logic             rs1_use;
    logic             rs2_use;
    logic [XLEN-1:0]  rs1_dat;
    logic [XLEN-1:0]  rs2_dat;
    logic [RF_AW-1:0] rd;
    logic             rd_we;
  } entry_t;

  id_ex_state_t    state, state_nxt;
  entry_t          entry, entry_nxt;
  logic            full;
  logic            fire;
  logic            capture;
  logic            stall_rs1;
  logic            stall_rs2;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  logic [XLEN-1:0] cap_rs1_dat;
  logic [XLEN-1:0] cap_rs2_dat;

  assign full         = (state == ID_EX_FULL);
  assign bus.ex_valid = full && !stall_rs1 && !stall_rs2;
  assign fire         = bus.ex_valid && bus.ex_ready;
  assign bus.id_ready = !full || fire;
  assign capture      = bus.id_valid && bus.id_ready && !bus.flush;

  // The register file read misses a same-cycle WB write, so bypass it at capture
  assign cap_rs1_dat = (bus.fwd_wb_we && (bus.id_rs1 != '0) && (bus.fwd_wb_rd == bus.id_rs1))
                       ? bus.fwd_wb_data : bus.id_rs1_data;
  assign cap_rs2_dat = (bus.fwd_wb_we && (bus.id_rs2 != '0) && (bus.fwd_wb_rd == bus.id_rs2))
                       ? bus.fwd_wb_data : bus.id_rs2_data;

  ama_riscv_fwd_mux #(.RF_AW(RF_AW), .XLEN(XLEN)) u_fwd_rs1 (
    .rs_use   (entry.rs1_use),
    .rs       (entry.rs1),
    .rs_dat   (entry.rs1_dat),
    .mem_we   (bus.fwd_mem_we),
    .mem_rd   (bus.fwd_mem_rd),
    .mem_dat  (bus.fwd_mem_data),
    .mem_pend (bus.fwd_mem_pend),
    .wb_we    (bus.fwd_wb_we),
    .wb_rd    (bus.fwd_wb_rd),
    .wb_dat   (bus.fwd_wb_data),
    .fwd_dat  (fwd_rs1),
    .stall    (stall_rs1)
  );

  ama_riscv_fwd_mux #(.RF_AW(RF_AW), .XLEN(XLEN)) u_fwd_rs2 (
    .rs_use   (entry.rs2_use),
    .rs       (entry.rs2),
    .rs_dat   (entry.rs2_dat),
    .mem_we   (bus.fwd_mem_we),
    .mem_rd   (bus.fwd_mem_rd),
    .mem_dat  (bus.fwd_mem_data),
    .mem_pend (bus.fwd_mem_pend),
    .wb_we    (bus.fwd_wb_we),
    .wb_rd    (bus.fwd_wb_rd),
    .wb_dat   (bus.fwd_wb_data),
    .fwd_dat  (fwd_rs2),
    .stall    (stall_rs2)
  );

  always_comb begin
    state_nxt = state;
    entry_nxt = entry;

    if (bus.flush) begin
      state_nxt = ID_EX_EMPTY;
    end else if (capture) begin
      state_nxt = ID_EX_FULL;
    end else if (fire) begin
      state_nxt = ID_EX_EMPTY;
    end

    if (capture) begin
      entry_nxt.pc      = bus.id_pc;
      entry_nxt.imm     = bus.id_imm;
      entry_nxt.op_sel  = bus.id_op_sel;
      entry_nxt.a_sel   = bus.id_a_sel;
      entry_nxt.b_sel   = bus.id_b_sel;
      entry_nxt.rs1     = bus.id_rs1;
      entry_nxt.rs2     = bus.id_rs2;
      entry_nxt.rs1_use = bus.id_rs1_use;
      entry_nxt.rs2_use = bus.id_rs2_use;
      entry_nxt.rs1_dat = cap_rs1_dat;
      entry_nxt.rs2_dat = cap_rs2_dat;
      entry_nxt.rd      = bus.id_rd;
      entry_nxt.rd_we   = bus.id_rd_we;
    end else if (full && !fire) begin
      // Producers retire while we hold; latch their results before they leave WB
      entry_nxt.rs1_dat = fwd_rs1;
      entry_nxt.rs2_dat = fwd_rs2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ID_EX_EMPTY;
      entry <= '0;
    end else begin
      state <= state_nxt;
      entry <= entry_nxt;
    end
  end

  assign bus.ex_op_sel     = entry.op_sel;
  assign bus.ex_in_a       = (entry.a_sel == ALU_A_PC)  ? entry.pc  : fwd_rs1;
  assign bus.ex_in_b       = (entry.b_sel == ALU_B_IMM) ? entry.imm : fwd_rs2;
  assign bus.ex_store_data = fwd_rs2;
  assign bus.ex_pc         = entry.pc;
  assign bus.ex_rd         = entry.rd;
  assign bus.ex_rd_we      = entry.rd_we && bus.ex_valid;

endmodule
